// File: rtl/alu_pkg.sv
// Shared opcode encoding, flag bit positions and control FSM states for alu_seq.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_ADC   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_SBC   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_EOR   = 4'h6;
    localparam logic [3:0] OP_ASR   = 4'h7;
    localparam logic [3:0] OP_LSR   = 4'h8;
    localparam logic [3:0] OP_ROR   = 4'h9;
    localparam logic [3:0] OP_SWAP  = 4'hA;
    localparam logic [3:0] OP_MUL   = 4'hB;
    localparam logic [3:0] OP_MULS  = 4'hC;
    localparam logic [3:0] OP_MULSU = 4'hD;
    localparam logic [3:0] OP_FMUL  = 4'hE;
    // 4'hF is unassigned and produces ro=0, flags=0.

    // Flag vector layout is {H,S,V,N,Z,C}.
    localparam int F_C = 0;
    localparam int F_Z = 1;
    localparam int F_N = 2;
    localparam int F_V = 3;
    localparam int F_S = 4;
    localparam int F_H = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_MUL_FIX = 2'd2
    } state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULS) || (op == OP_MULSU) || (op == OP_FMUL);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bus between the issue stage and alu_seq.
interface alu_seq_if #(
    parameter int WIDTH = 8
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           op;
    logic [WIDTH-1:0]     ai;
    logic [WIDTH-1:0]     bi;
    logic                 ci;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   ro;
    logic [5:0]           flags;

    modport master (
        output in_valid, op, ai, bi, ci, out_ready,
        input  in_ready, out_valid, ro, flags
    );

    modport slave (
        input  in_valid, op, ai, bi, ci, out_ready,
        output in_ready, out_valid, ro, flags
    );
endinterface

// File: rtl/alu_mul_core.sv
// Iterative shift-add multiplier: sign/magnitude split on start, RADIX bits of B
// per cycle, then a combinational sign fix and optional FMUL shift on the result.
module alu_mul_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RADIX = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   ai,
    input  logic [WIDTH-1:0]   bi,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               c
);
    localparam int STEPS = WIDTH / RADIX;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    logic [2*WIDTH-1:0] acc_q, a_sh_q, pp, fixed;
    logic [WIDTH-1:0]   b_q, a_mag, b_mag;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q, neg_q, fmul_q, a_neg, b_neg;

    // Split operands into sign and magnitude; -2^(W-1) maps to 2^(W-1) unsigned.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        a_neg = 1'b0;
        b_neg = 1'b0;
        if (op == OP_MULS || op == OP_MULSU) a_neg = ai[WIDTH-1];
        if (op == OP_MULS)                   b_neg = bi[WIDTH-1];
        a_mag = a_neg ? -ai : ai;
        b_mag = b_neg ? -bi : bi;
    end

    // Partial product for the RADIX multiplier bits retired this cycle.
    always_comb begin
        pp = '0;
        for (int i = 0; i < RADIX; i++) begin
            if (b_q[i]) pp = pp + (a_sh_q << i);
        end
    end

    // Accumulator, shifting multiplicand/multiplier and step counter.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with <= so every register samples pre-edge values.
        if (rst) begin
            acc_q  <= '0;
            a_sh_q <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            neg_q  <= 1'b0;
            fmul_q <= 1'b0;
        end else if (start) begin
            acc_q  <= '0;
            a_sh_q <= {{WIDTH{1'b0}}, a_mag};
            b_q    <= b_mag;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            neg_q  <= a_neg ^ b_neg;
            fmul_q <= (op == OP_FMUL);
        end else if (busy_q) begin
            acc_q  <= acc_q + pp;
            a_sh_q <= a_sh_q << RADIX;
            b_q    <= b_q >> RADIX;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (done) busy_q <= 1'b0;
        end
    end

    // done marks the cycle retiring the last step; the result is valid the cycle after.
    assign done    = busy_q && (cnt_q == CNT_W'(STEPS - 1));
    assign fixed   = neg_q ? -acc_q : acc_q;
    assign c       = fixed[2*WIDTH-1];
    assign product = fmul_q ? {fixed[2*WIDTH-2:0], 1'b0} : fixed;
endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake: single-cycle byte ops plus a
// multi-cycle multiply group sequenced by a small FSM.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RADIX = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    alu_seq_if.slave bus
);
    localparam int MSB  = WIDTH - 1;
    localparam int HALF = WIDTH / 2;

    state_e             state_q, state_d;
    logic               in_ready, accept, mul_start, op_load, fix_load;
    logic               mul_done, mul_c;
    logic [2*WIDTH-1:0] mul_product, ro_q;
    logic [5:0]         flags_q, op_flags, mul_flags;
    logic [WIDTH-1:0]   op_res;
    logic [WIDTH:0]     sum, diff;
    logic [4:0]         hsum, hdiff;
    logic               cin, c_f, h_f, v_f, n_f, nz_en, out_valid_q;

    alu_mul_core #(.WIDTH(WIDTH), .RADIX(RADIX)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .op      (bus.op),
        .ai      (bus.ai),
        .bi      (bus.bi),
        .done    (mul_done),
        .product (mul_product),
        .c       (mul_c)
    );

    // Single-cycle datapath; flags an op does not define are reported as 0.
    always_comb begin
        cin    = (bus.op == OP_ADC || bus.op == OP_SBC) ? bus.ci : 1'b0;
        sum    = {1'b0, bus.ai} + {1'b0, bus.bi} + {{WIDTH{1'b0}}, cin};
        diff   = {1'b0, bus.ai} - {1'b0, bus.bi} - {{WIDTH{1'b0}}, cin};
        hsum   = {1'b0, bus.ai[3:0]} + {1'b0, bus.bi[3:0]} + {4'b0, cin};
        hdiff  = {1'b0, bus.ai[3:0]} - {1'b0, bus.bi[3:0]} - {4'b0, cin};
        op_res = '0;
        c_f    = 1'b0;
        h_f    = 1'b0;
        v_f    = 1'b0;
        nz_en  = 1'b1;
        case (bus.op)
            OP_ADD, OP_ADC: begin
                op_res = sum[MSB:0];
                c_f    = sum[WIDTH];
                h_f    = hsum[4];
                v_f    = (bus.ai[MSB] == bus.bi[MSB]) && (op_res[MSB] != bus.ai[MSB]);
            end
            // C and H carry the borrow, not the inverted carry.
            OP_SUB, OP_SBC: begin
                op_res = diff[MSB:0];
                c_f    = diff[WIDTH];
                h_f    = hdiff[4];
                v_f    = (bus.ai[MSB] != bus.bi[MSB]) && (op_res[MSB] != bus.ai[MSB]);
            end
            OP_AND: op_res = bus.ai & bus.bi;
            OP_OR:  op_res = bus.ai | bus.bi;
            OP_EOR: op_res = bus.ai ^ bus.bi;
            OP_ASR, OP_LSR, OP_ROR: begin
                op_res = {bus.ai[MSB], bus.ai[MSB:1]};
                if (bus.op == OP_LSR) op_res[MSB] = 1'b0;
                if (bus.op == OP_ROR) op_res[MSB] = bus.ci;
                c_f = bus.ai[0];
                v_f = op_res[MSB] ^ bus.ai[0];
            end
            OP_SWAP: begin
                op_res = {bus.ai[HALF-1:0], bus.ai[MSB:HALF]};
                nz_en  = 1'b0;
            end
            default: nz_en = 1'b0;
        endcase
        n_f            = nz_en & op_res[MSB];
        op_flags       = '0;
        op_flags[F_C]  = c_f;
        op_flags[F_Z]  = nz_en & (op_res == '0);
        op_flags[F_N]  = n_f;
        op_flags[F_V]  = v_f;
        op_flags[F_S]  = n_f ^ v_f;
        op_flags[F_H]  = h_f;
        mul_flags      = '0;
        mul_flags[F_C] = mul_c;
        mul_flags[F_Z] = (mul_product == '0);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state; flush returns to IDLE from anywhere.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (mul_start) state_d = ST_MUL_RUN;
                ST_MUL_RUN: if (mul_done)  state_d = ST_MUL_FIX;
                ST_MUL_FIX: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: issue handshake and result-load strobes.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
        accept    = bus.in_valid && in_ready && !flush;
        mul_start = accept && is_mul_op(bus.op);
        op_load   = accept && !is_mul_op(bus.op);
        fix_load  = (state_q == ST_MUL_FIX) && !flush;
    end

    // Output register: loads on a result, holds under backpressure, flush drops valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ro_q        <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (op_load) begin
            ro_q        <= {{WIDTH{1'b0}}, op_res};
            flags_q     <= op_flags;
            out_valid_q <= 1'b1;
        end else if (fix_load) begin
            ro_q        <= mul_product;
            flags_q     <= mul_flags;
            out_valid_q <= 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.ro        = ro_q;
    assign bus.flags     = flags_q;
endmodule
